ibex_rf_cache_fill_ctrl: RTL and testbench

Sequences refills of the small register-cache (CACHE_LEN ways, holding operand values) from the backing 2-port register SRAM. On a read-operand miss it stalls the pipeline, issues SRAM reads for the A and/or B operand, and picks a round-robin victim way. It writes the returned data, plus tag, into the cache. It sits between the register cache tag compare and the SRAM read port, and replaces ad-hoc miss/stall logic inside the register file.

---
 rtl/ibex_rf_cache_fill_ctrl.sv | 141 ++++++++++++++
 tb/tb_ibex_rf_cache_fill_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_cache_fill_ctrl.sv
// Refill sequencer for the operand register cache: on a tag miss it stalls the pipeline,
// reads the backing register SRAM for operand A and/or B and writes them into round-robin ways.
module ibex_rf_cache_fill_ctrl #(
    parameter int unsigned CACHE_LEN = 4,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned CW       = $clog2(CACHE_LEN)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 miss_a_i,
    input  logic                 miss_b_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 flush_i,
    output logic                 sram_re_o,
    output logic [4:0]           sram_addr_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 fill_en_o,
    output logic [CW-1:0]        fill_way_o,
    output logic [4:0]           fill_tag_o,
    output logic [DataWidth-1:0] fill_data_o,
    output logic                 inval_o,
    output logic                 stall_o,
    output logic [15:0]          fill_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B
    } state_e;

    state_e        state_q;
    logic [CW-1:0] victim_q;
    logic [4:0]    addr_a_q;
    logic [4:0]    addr_b_q;
    logic          pend_b_q;
    logic          flush_pend_q;

    logic eff_a;
    logic eff_b;
    logic any_miss;
    logic do_inval;
    logic filling;

    // Register x0 is never cached, and a B miss on the same register as A rides on A's fill.
    assign eff_a    = miss_a_i & (raddr_a_i != 5'd0);
    assign eff_b    = miss_b_i & (raddr_b_i != 5'd0) & ~(eff_a & (raddr_b_i == raddr_a_i));
    assign any_miss = eff_a | eff_b;
    // A deferred flush owns the first IDLE cycle; new misses wait until it has gone out.
    assign do_inval = (state_q == IDLE) & (flush_pend_q | (flush_i & ~any_miss));
    assign filling  = (state_q != IDLE);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        sram_re_o   = 1'b0;
        sram_addr_o = 5'd0;
        fill_en_o   = 1'b0;
        fill_way_o  = '0;
        fill_tag_o  = 5'd0;
        fill_data_o = '0;
        inval_o     = 1'b0;
        stall_o     = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    inval_o = do_inval;
                    stall_o = any_miss;
                    if (!do_inval && any_miss) begin
                        sram_re_o   = 1'b1;
                        sram_addr_o = eff_a ? raddr_a_i : raddr_b_i;
                    end
                end
                RD_A, RD_B: begin
                    stall_o     = 1'b1;
                    fill_en_o   = 1'b1;
                    fill_way_o  = victim_q;
                    fill_tag_o  = (state_q == RD_B) ? addr_b_q : addr_a_q;
                    fill_data_o = (we_i && (waddr_i == fill_tag_o)) ? wdata_i : sram_rdata_i;
                    if (state_q == RD_A && pend_b_q) begin
                        sram_re_o   = 1'b1;
                        sram_addr_o = addr_b_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            addr_a_q     <= 5'd0;
            addr_b_q     <= 5'd0;
            pend_b_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            fill_cnt_o   <= 16'd0;
        end else begin
            if (filling && fill_cnt_o != 16'hFFFF) begin
                fill_cnt_o <= fill_cnt_o + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (do_inval) begin
                        victim_q     <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (eff_a) begin
                        addr_a_q     <= raddr_a_i;
                        pend_b_q     <= eff_b;
                        if (eff_b) addr_b_q <= raddr_b_i;
                        flush_pend_q <= flush_i;
                        state_q      <= RD_A;
                    end else if (eff_b) begin
                        addr_b_q     <= raddr_b_i;
                        pend_b_q     <= 1'b0;
                        flush_pend_q <= flush_i;
                        state_q      <= RD_B;
                    end
                end
                RD_A: begin
                    victim_q <= victim_q + CW'(1);
                    pend_b_q <= 1'b0;
                    if (flush_i) flush_pend_q <= 1'b1;
                    state_q  <= pend_b_q ? RD_B : IDLE;
                end
                RD_B: begin
                    victim_q <= victim_q + CW'(1);
                    if (flush_i) flush_pend_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_cache_fill_ctrl.sv
// Directed bench for ibex_rf_cache_fill_ctrl: a behavioural SRAM with one-cycle read latency
// feeds the DUT; inputs change just after posedge and outputs are sampled on the negedge.
module tb_ibex_rf_cache_fill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        miss_a_i, miss_b_i;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        sram_re_o;
    logic [4:0]  sram_addr_o;
    logic [31:0] sram_rdata_i;
    logic        fill_en_o;
    logic [1:0]  fill_way_o;
    logic [4:0]  fill_tag_o;
    logic [31:0] fill_data_o;
    logic        inval_o;
    logic        stall_o;
    logic [15:0] fill_cnt_o;

    logic [31:0] mem [32];
    int passed = 0;
    int total  = 0;

    ibex_rf_cache_fill_ctrl #(.CACHE_LEN(4), .DataWidth(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .miss_a_i     (miss_a_i),
        .miss_b_i     (miss_b_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .sram_re_o    (sram_re_o),
        .sram_addr_o  (sram_addr_o),
        .sram_rdata_i (sram_rdata_i),
        .fill_en_o    (fill_en_o),
        .fill_way_o   (fill_way_o),
        .fill_tag_o   (fill_tag_o),
        .fill_data_o  (fill_data_o),
        .inval_o      (inval_o),
        .stall_o      (stall_o),
        .fill_cnt_o   (fill_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (sram_re_o) sram_rdata_i <= mem[sram_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic set_miss(input logic ma, input logic [4:0] a, input logic mb, input logic [4:0] b);
        miss_a_i  = ma;
        raddr_a_i = a;
        miss_b_i  = mb;
        raddr_b_i = b;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
        mem[5] = 32'hDEADBEEF;
        sram_rdata_i = 32'd0;
        rst_ni  = 1'b0;
        we_i    = 1'b0;
        waddr_i = 5'd0;
        wdata_i = 32'd0;
        flush_i = 1'b1;
        set_miss(1'b1, 5'd5, 1'b0, 5'd0);

        // Outputs stay quiet during reset even with a miss and flush presented.
        settle();
        check("rst_re",    32'(sram_re_o),  32'd0);
        check("rst_stall", 32'(stall_o),    32'd0);
        check("rst_inval", 32'(inval_o),    32'd0);
        check("rst_cnt",   32'(fill_cnt_o), 32'd0);

        cyc();
        rst_ni  = 1'b1;
        flush_i = 1'b0;
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("idle_stall", 32'(stall_o), 32'd0);

        // Single A miss on x5.
        cyc();
        set_miss(1'b1, 5'd5, 1'b0, 5'd0);
        settle();
        check("t1_re",    32'(sram_re_o),   32'd1);
        check("t1_addr",  32'(sram_addr_o), 32'd5);
        check("t1_stall", 32'(stall_o),     32'd1);
        check("t1_nofill", 32'(fill_en_o),  32'd0);
        cyc();
        settle();
        check("t1_fill",  32'(fill_en_o),   32'd1);
        check("t1_way",   32'(fill_way_o),  32'd0);
        check("t1_tag",   32'(fill_tag_o),  32'd5);
        check("t1_data",  fill_data_o,      32'hDEADBEEF);
        check("t1_stall_fill", 32'(stall_o), 32'd1);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("t1_stall_end", 32'(stall_o), 32'd0);
        check("t1_cnt",   32'(fill_cnt_o),  32'd1);

        // Dual miss a=3 b=7: back-to-back fills into ways 1 and 2.
        cyc();
        set_miss(1'b1, 5'd3, 1'b1, 5'd7);
        settle();
        check("t2_re_a",  32'(sram_addr_o), 32'd3);
        cyc();
        settle();
        check("t2_way_a", 32'(fill_way_o),  32'd1);
        check("t2_tag_a", 32'(fill_tag_o),  32'd3);
        check("t2_data_a", fill_data_o,     32'hA0000003);
        check("t2_re_b",  32'(sram_re_o),   32'd1);
        check("t2_addr_b", 32'(sram_addr_o), 32'd7);
        cyc();
        settle();
        check("t2_fill_b", 32'(fill_en_o),  32'd1);
        check("t2_way_b", 32'(fill_way_o),  32'd2);
        check("t2_tag_b", 32'(fill_tag_o),  32'd7);
        check("t2_data_b", fill_data_o,     32'hA0000007);
        check("t2_stall3", 32'(stall_o),    32'd1);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("t2_stall_end", 32'(stall_o), 32'd0);
        check("t2_cnt",   32'(fill_cnt_o),  32'd3);

        // Same register on both ports: single fill.
        cyc();
        set_miss(1'b1, 5'd9, 1'b1, 5'd9);
        settle();
        check("t3_addr",  32'(sram_addr_o), 32'd9);
        cyc();
        settle();
        check("t3_way",   32'(fill_way_o),  32'd3);
        check("t3_tag",   32'(fill_tag_o),  32'd9);
        check("t3_no_re_b", 32'(sram_re_o), 32'd0);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("t3_idle",  32'(fill_en_o),   32'd0);
        check("t3_stall_end", 32'(stall_o), 32'd0);
        check("t3_cnt",   32'(fill_cnt_o),  32'd4);

        // Write forwarding during the fill of x4; victim has wrapped to way 0.
        cyc();
        set_miss(1'b1, 5'd4, 1'b0, 5'd0);
        cyc();
        we_i    = 1'b1;
        waddr_i = 5'd4;
        wdata_i = 32'h12345678;
        settle();
        check("t4_way",   32'(fill_way_o),  32'd0);
        check("t4_fwd",   fill_data_o,      32'h12345678);
        cyc();
        we_i = 1'b0;
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);

        // Flush in idle: immediate invalidate, victim back to 0.
        flush_i = 1'b1;
        settle();
        check("fl_inval", 32'(inval_o),     32'd1);
        check("fl_stall", 32'(stall_o),     32'd0);
        cyc();
        flush_i = 1'b0;
        settle();
        check("fl_pulse", 32'(inval_o),     32'd0);

        // Five single misses walk the ways 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            cyc();
            set_miss(1'b1, 5'(10 + i), 1'b0, 5'd0);
            cyc();
            settle();
            check("t5_way", 32'(fill_way_o), 32'(i % 4));
            check("t5_tag", 32'(fill_tag_o), 32'(10 + i));
            cyc();
            set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        end
        settle();
        check("t5_cnt",   32'(fill_cnt_o),  32'd10);

        // Flush during RD_A is deferred, then blocks a waiting miss for one cycle.
        cyc();
        set_miss(1'b1, 5'd20, 1'b0, 5'd0);
        cyc();
        flush_i = 1'b1;
        settle();
        check("fp_fill",  32'(fill_en_o),   32'd1);
        check("fp_way",   32'(fill_way_o),  32'd1);
        check("fp_noinv", 32'(inval_o),     32'd0);
        cyc();
        flush_i = 1'b0;
        set_miss(1'b1, 5'd21, 1'b0, 5'd0);
        settle();
        check("fp_inval", 32'(inval_o),     32'd1);
        check("fp_stall", 32'(stall_o),     32'd1);
        check("fp_hold",  32'(sram_re_o),   32'd0);
        cyc();
        settle();
        check("fp_inv1",  32'(inval_o),     32'd0);
        check("fp_re",    32'(sram_addr_o), 32'd21);
        cyc();
        settle();
        check("fp_way0",  32'(fill_way_o),  32'd0);
        check("fp_tag",   32'(fill_tag_o),  32'd21);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("fp_cnt",   32'(fill_cnt_o),  32'd12);

        // Register x0 misses are ignored.
        cyc();
        set_miss(1'b1, 5'd0, 1'b1, 5'd0);
        settle();
        check("x0_re",    32'(sram_re_o),   32'd0);
        check("x0_stall", 32'(stall_o),     32'd0);

        // B-only miss goes straight to RD_B.
        cyc();
        set_miss(1'b0, 5'd0, 1'b1, 5'd6);
        settle();
        check("b_addr",   32'(sram_addr_o), 32'd6);
        cyc();
        settle();
        check("b_way",    32'(fill_way_o),  32'd1);
        check("b_tag",    32'(fill_tag_o),  32'd6);
        check("b_data",   fill_data_o,      32'hA0000006);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("b_stall_end", 32'(stall_o),  32'd0);

        // Reset asserted while in RD_A abandons the fill.
        cyc();
        set_miss(1'b1, 5'd8, 1'b0, 5'd0);
        cyc();
        rst_ni = 1'b0;
        settle();
        check("mr_fill",  32'(fill_en_o),   32'd0);
        check("mr_stall", 32'(stall_o),     32'd0);
        check("mr_cnt",   32'(fill_cnt_o),  32'd0);
        cyc();
        rst_ni = 1'b1;
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("mr_idle",  32'(stall_o),     32'd0);
        check("mr_nofill", 32'(fill_en_o),  32'd0);
        cyc();
        set_miss(1'b1, 5'd5, 1'b0, 5'd0);
        settle();
        check("mr_re",    32'(sram_re_o),   32'd1);
        cyc();
        settle();
        check("mr_way0",  32'(fill_way_o),  32'd0);
        check("mr_data",  fill_data_o,      32'hDEADBEEF);
        cyc();
        set_miss(1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check("mr_cnt1",  32'(fill_cnt_o),  32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
